// File: rtl/mul8_sequencer.sv
// 8x8 unsigned multiply sequencer driving a shared 4x4 array multiplier.
// Ports: start_* operand handshake, mul_a/mul_b/mul_p array link,
//        res_* result handshake, result, busy; MUL8_ACC_EN adds acc_clr.
module mul8_sequencer
`ifdef MUL8_ACC_EN
  #(parameter int ACC_EXTRA = 4)
`endif
  (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        res_valid,
  input  logic        res_ready,
`ifdef MUL8_ACC_EN
  output logic [16+ACC_EXTRA-1:0] result,
  output logic        busy,
  input  logic        acc_clr
`else
  output logic [15:0] result,
  output logic        busy
`endif
);

`ifdef MUL8_ACC_EN
  localparam int RES_W = 16 + ACC_EXTRA;
`else
  localparam int RES_W = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [RES_W-1:0] pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= 2'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mul_a    = 4'd0;
    mul_b    = 4'd0;
    pp       = '0;
    unique case (state_q)
      S_IDLE: begin
`ifdef MUL8_ACC_EN
        // clear wins first, so an accept with acc_clr starts from 0
        if (acc_clr) result_d = '0;
`endif
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          step_d  = 2'd0;
          state_d = S_MUL;
`ifndef MUL8_ACC_EN
          result_d = '0;
`endif
        end
      end
      S_MUL: begin
        // step bit0 picks the a nibble, bit1 the b nibble
        mul_a = step_q[0] ? a_q[7:4] : a_q[3:0];
        mul_b = step_q[1] ? b_q[7:4] : b_q[3:0];
        unique case (step_q)
          2'd0:    pp = RES_W'(mul_p);
          2'd3:    pp = RES_W'(mul_p) << 8;
          default: pp = RES_W'(mul_p) << 4;
        endcase
        result_d = result_q + pp;
        step_d   = step_q + 2'd1;
        if (step_q == 2'd3) state_d = S_DONE;
      end
      S_DONE: begin
`ifdef MUL8_ACC_EN
        if (acc_clr) result_d = '0;
`endif
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_ready = rst_n && (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_MUL) || (state_q == S_DONE);
  assign result      = result_q;

endmodule

// File: tb/tb_mul8_sequencer.sv
// Self-checking bench for mul8_sequencer with a behavioural 4x4 array
// and an arithmetic reference model of the full product/accumulator.
module tb_mul8_sequencer;

`ifdef MUL8_ACC_EN
  localparam int RW = 20;
`else
  localparam int RW = 16;
`endif

  logic          clk;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [7:0]    a_in;
  logic [7:0]    b_in;
  logic [3:0]    mul_a;
  logic [3:0]    mul_b;
  logic [7:0]    mul_p;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] result;
  logic          busy;
`ifdef MUL8_ACC_EN
  logic          acc_clr;
  logic [RW-1:0] acc;
  bit            clr_in_mul;
`endif

  int checks = 0;
  int errors = 0;

  mul8_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_p       (mul_p),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
`ifdef MUL8_ACC_EN
    .busy        (busy),
    .acc_clr     (acc_clr)
`else
    .busy        (busy)
`endif
  );

  assign mul_p = 8'(mul_a) * 8'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] model(input logic [7:0] a,
                                          input logic [7:0] b);
`ifdef MUL8_ACC_EN
    acc = RW'(int'(acc) + int'(a) * int'(b));
    return acc;
`else
    return RW'(int'(a) * int'(b));
`endif
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int hold);
    logic [RW-1:0] exp;
    logic [3:0]    ea [4];
    logic [3:0]    eb [4];
    exp = model(a, b);
    ea = '{a[3:0], a[7:4], a[3:0], a[7:4]};
    eb = '{b[3:0], b[3:0], b[7:4], b[7:4]};
    chk("idle_ready", 32'(start_ready), 32'd1);
    chk("idle_mul_a", 32'(mul_a), 32'd0);
    start_valid = 1'b1;
    a_in = a;
    b_in = b;
    tick();
    start_valid = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
`ifdef MUL8_ACC_EN
      acc_clr = clr_in_mul;
`endif
      chk($sformatf("step%0d_mul_a", k), 32'(mul_a), 32'(ea[k]));
      chk($sformatf("step%0d_mul_b", k), 32'(mul_b), 32'(eb[k]));
      chk($sformatf("step%0d_valid", k), 32'(res_valid), 32'd0);
      chk($sformatf("step%0d_busy", k), 32'(busy), 32'd1);
      chk($sformatf("step%0d_ready", k), 32'(start_ready), 32'd0);
      tick();
    end
`ifdef MUL8_ACC_EN
    acc_clr = 1'b0;
`endif
    chk("done_valid", 32'(res_valid), 32'd1);
    chk("done_result", 32'(result), 32'(exp));
    chk("done_mul_a", 32'(mul_a), 32'd0);
    chk("done_mul_b", 32'(mul_b), 32'd0);
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      tick();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(exp));
      chk("hold_ready", 32'(start_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_valid", 32'(res_valid), 32'd0);
    chk("post_ready", 32'(start_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_result", 32'(result), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    a_in = 8'd0;
    b_in = 8'd0;
`ifdef MUL8_ACC_EN
    acc_clr = 1'b0;
    acc = '0;
    clr_in_mul = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    tick();

    run_op(8'h2B, 8'h5C, 0);
`ifndef MUL8_ACC_EN
    chk("dir_2b5c", 32'(result), 32'h0F74);
`endif

    run_op(8'hFF, 8'hFF, 10);
`ifndef MUL8_ACC_EN
    chk("dir_ffff", 32'(result), 32'hFE01);
`endif

    start_valid = 1'b1;
    a_in = 8'h80;
    b_in = 8'h02;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_mul_a", 32'(mul_a), 32'd0);
    chk("abort_mul_b", 32'(mul_b), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
`ifdef MUL8_ACC_EN
    acc = '0;
`endif
    tick();
    run_op(8'h80, 8'h02, 0);
`ifndef MUL8_ACC_EN
    chk("dir_8002", 32'(result), 32'h0100);
`endif

    run_op(8'h00, 8'hA7, 0);
    run_op(8'h01, 8'hFF, 0);
`ifndef MUL8_ACC_EN
    chk("dir_01ff", 32'(result), 32'h00FF);
`endif

    for (int i = 0; i < 12; i++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

`ifdef MUL8_ACC_EN
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    acc = '0;
    chk("acc_clr_idle", 32'(result), 32'd0);
    for (int r = 0; r < 3; r++) run_op(8'hFF, 8'hFF, 0);
    chk("acc_three", 32'(result), 32'h2FA03);
    clr_in_mul = 1'b1;
    run_op(8'h12, 8'h34, 0);
    clr_in_mul = 1'b0;
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    acc = '0;
    chk("acc_clr_idle2", 32'(result), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom), 8'($urandom), 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
